// File: rtl/tnnzeq_pkg.sv
// Shared types and helpers for the tnnzeq neuron sequencer and its accumulator.
package tnnzeq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_BIAS,
    S_RUN,
    S_DONE
  } state_t;

  // Applies a ternary weight sign to an unsigned feature. The caller keeps the
  // low BITS+1 bits; negating an unsigned BITS-wide value always fits there.
  function automatic logic signed [31:0] sgn_ext(input logic [31:0] x, input logic neg);
    logic signed [31:0] v;
    v = $signed(x);
    return neg ? -v : v;
  endfunction

  // Accumulator width that holds SIZE terms of magnitude up to 2^BITS-1 plus sign.
  function automatic int to_acc_w(input int bits, input int size);
    return bits + $clog2(size + 1) + 1;
  endfunction

endpackage

// File: rtl/tnnzeq_feature_mux.sv
// Latched feature register plus weight-indexed select and sign application.
// The select is combinational from k; out-of-range weight indices fall back
// to feature 0 and are reported at elaboration.
module tnnzeq_feature_mux
  import tnnzeq_pkg::*;
#(
  parameter int FEAT  = 16,
  parameter int BITS  = 8,
  parameter int SIZE  = 4,
  parameter int IDX_W = $clog2(FEAT),
  parameter int K_W   = $clog2(SIZE + 1),
  parameter logic [SIZE*IDX_W-1:0] WIDX = '0,
  parameter logic [SIZE-1:0]       WSGN = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [FEAT*BITS-1:0]   features,
  input  logic [K_W-1:0]         k,
  output logic signed [BITS:0]   value
);

  logic [FEAT*BITS-1:0] feat_q;
  logic [IDX_W-1:0]     sel;
  logic [BITS-1:0]      x;

  // A wiring mistake in WIDX must be caught before simulation starts.
  for (genvar g = 0; g < SIZE; g++) begin : g_chk
    if (int'(WIDX[g*IDX_W +: IDX_W]) >= FEAT) begin : g_bad
      $error("tnnzeq_feature_mux: WIDX entry %0d selects feature %0d, FEAT is %0d",
             g, int'(WIDX[g*IDX_W +: IDX_W]), FEAT);
    end
  end

  // Feature vector is captured once per accepted start and held for the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      feat_q <= '0;
    end else if (load) begin
      feat_q <= features;
    end
  end

  // Pick weight k's feature and apply its sign; k past the last weight reads weight 0.
  always_comb begin
    int ki;
    int si;
    ki = int'(k);
    if (ki >= SIZE) ki = 0;
    sel = WIDX[ki*IDX_W +: IDX_W];
    si  = int'(sel);
    if (si < FEAT) x = feat_q[si*BITS +: BITS];
    else           x = feat_q[BITS-1:0];
    value = (BITS+1)'(sgn_ext({{(32-BITS){1'b0}}, x}, WSGN[ki]));
  end

endmodule

// File: rtl/tnnzeq_neuron_sequencer.sv
// Control-and-feed stage for the tnnzeq serial ternary neuron accumulator.
// Latches features on start, clears the accumulator, streams one signed feature
// per non-zero weight, then captures the accumulator sign and pulses done.
// Optional bias term: define TNNZEQ_SEQ_BIAS_EN to add parameter BIAS and a
// one-cycle BIAS state between CLEAR and RUN.
module tnnzeq_neuron_sequencer
  import tnnzeq_pkg::*;
#(
  parameter int FEAT  = 16,
  parameter int BITS  = 8,
  parameter int SIZE  = 4,
  parameter int IDX_W = $clog2(FEAT),
  parameter logic [SIZE*IDX_W-1:0] WIDX = '0,
  parameter logic [SIZE-1:0]       WSGN = '0
`ifdef TNNZEQ_SEQ_BIAS_EN
  ,
  parameter logic signed [BITS:0]  BIAS = '0
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FEAT*BITS-1:0]  features,
  input  logic                  acc_out,
  output logic signed [BITS:0]  sample,
  output logic                  halt,
  output logic                  acc_clr,
  output logic                  busy,
  output logic                  done,
  output logic                  result
);

  localparam int K_W = $clog2(SIZE + 1);
  localparam logic [K_W-1:0] LAST = K_W'(SIZE - 1);

  state_t                state, state_nxt;
  logic [K_W-1:0]        k, k_nxt;
  logic                  load;
  logic                  capture;
  logic signed [BITS:0]  mux_value;
  logic signed [BITS:0]  sample_nxt;

  // Feature select is driven with the index of the cycle being set up, so the
  // registered sample lines up with the RUN cycle that consumes it.
  tnnzeq_feature_mux #(
    .FEAT  (FEAT),
    .BITS  (BITS),
    .SIZE  (SIZE),
    .IDX_W (IDX_W),
    .K_W   (K_W),
    .WIDX  (WIDX),
    .WSGN  (WSGN)
  ) u_mux (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .features (features),
    .k        (k_nxt),
    .value    (mux_value)
  );

  // Next-state, weight counter and capture decode.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        k_nxt = '0;
`ifdef TNNZEQ_SEQ_BIAS_EN
        state_nxt = S_BIAS;
`else
        state_nxt = S_RUN;
`endif
      end
      S_BIAS: begin
        k_nxt     = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        k_nxt = k + 1'b1;
        // acc_out already folds in this cycle's sample, so it is the final sign.
        if (k == LAST) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Value to present to the accumulator during the upcoming cycle.
  always_comb begin
    sample_nxt = '0;
    if (state_nxt == S_RUN) begin
      sample_nxt = mux_value;
    end
`ifdef TNNZEQ_SEQ_BIAS_EN
    else if (state_nxt == S_BIAS) begin
      sample_nxt = BIAS;
    end
`endif
  end

  // State, counter and registered accumulator controls decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      sample  <= '0;
      halt    <= 1'b1;
      acc_clr <= 1'b0;
      done    <= 1'b0;
      result  <= 1'b0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      sample  <= sample_nxt;
      halt    <= !((state_nxt == S_RUN) || (state_nxt == S_BIAS));
      acc_clr <= (state_nxt == S_CLEAR);
      done    <= (state_nxt == S_DONE);
      if (capture) begin
        result <= acc_out;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_tnnzeq_neuron_sequencer.sv
// Self-checking bench for tnnzeq_neuron_sequencer with an attached accumulator.
module tb_tnnzeq_neuron_sequencer;
  import tnnzeq_pkg::*;

  localparam int FEAT  = 4;
  localparam int BITS  = 8;
  localparam int SIZE  = 2;
  localparam int IDX_W = 2;
  localparam logic [SIZE*IDX_W-1:0] WIDX = 4'b0010;   // k1 -> feature 0, k0 -> feature 2
  localparam logic [SIZE-1:0] WSGN_A = 2'b10;
  localparam logic [SIZE-1:0] WSGN_B = 2'b11;
`ifdef TNNZEQ_SEQ_BIAS_EN
  localparam int NB    = 1;
  localparam int BIASV = -8;
  localparam logic signed [BITS:0] BIAS_P = -9'sd8;
`else
  localparam int NB    = 0;
  localparam int BIASV = 0;
`endif
  localparam int ACC_W = to_acc_w(BITS, SIZE + NB);
  localparam int P     = SIZE + 3 + NB;   // back-to-back period with start held high

  logic                  clk, rst;
  logic                  start, acc_out, halt, acc_clr, busy, done, result;
  logic [FEAT*BITS-1:0]  features;
  logic signed [BITS:0]  sample;
  logic                  start_n, acc_out_n, halt_n, acc_clr_n, busy_n, done_n, result_n;
  logic [FEAT*BITS-1:0]  features_n;
  logic signed [BITS:0]  sample_n;

  logic signed [ACC_W-1:0] acc, next_acc, acc_n, next_acc_n;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  tnnzeq_neuron_sequencer #(
    .FEAT(FEAT), .BITS(BITS), .SIZE(SIZE), .IDX_W(IDX_W), .WIDX(WIDX), .WSGN(WSGN_A)
`ifdef TNNZEQ_SEQ_BIAS_EN
    , .BIAS(BIAS_P)
`endif
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .features(features), .acc_out(acc_out),
    .sample(sample), .halt(halt), .acc_clr(acc_clr), .busy(busy), .done(done), .result(result)
  );

  tnnzeq_neuron_sequencer #(
    .FEAT(FEAT), .BITS(BITS), .SIZE(SIZE), .IDX_W(IDX_W), .WIDX(WIDX), .WSGN(WSGN_B)
`ifdef TNNZEQ_SEQ_BIAS_EN
    , .BIAS(BIAS_P)
`endif
  ) u_neg (
    .clk(clk), .rst(rst), .start(start_n), .features(features_n), .acc_out(acc_out_n),
    .sample(sample_n), .halt(halt_n), .acc_clr(acc_clr_n), .busy(busy_n), .done(done_n),
    .result(result_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached serial accumulators.
  always_comb begin
    next_acc   = halt   ? acc   : acc   + $signed({{(ACC_W-BITS-1){sample[BITS]}}, sample});
    next_acc_n = halt_n ? acc_n : acc_n + $signed({{(ACC_W-BITS-1){sample_n[BITS]}}, sample_n});
  end
  assign acc_out   = !next_acc[ACC_W-1];
  assign acc_out_n = !next_acc_n[ACC_W-1];

  always_ff @(posedge clk) begin
    acc   <= (rst || acc_clr)   ? '0 : next_acc;
    acc_n <= (rst || acc_clr_n) ? '0 : next_acc_n;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: expected sample stream and output from the weight list.
  function automatic int build_exp(input logic [31:0] f, input logic [SIZE-1:0] sgn);
    int sum;
    exp_q.delete();
    sum = 0;
    if (NB != 0) begin
      exp_q.push_back(BIASV);
      sum += BIASV;
    end
    for (int w = 0; w < SIZE; w++) begin
      int idx, x;
      idx = (int'(WIDX) >> (w * IDX_W)) % (1 << IDX_W);
      x   = (int'(f) >> (idx * BITS)) & 255;
      if (sgn[w]) x = -x;
      exp_q.push_back(x);
      sum += x;
    end
    return (sum >= 0) ? 1 : 0;
  endfunction

  // One full inference on u_dut; start is also pulsed while busy and features are scrambled.
  task automatic run_txn(input logic [31:0] f, input int exp_res, input string tag);
    @(negedge clk);
    features = f;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_clr"},  int'(acc_clr), 1);
    chk({tag, "_halt_clr"}, int'(halt), 1);
    chk({tag, "_busy"}, int'(busy), 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      features = $urandom;
      start    = 1'b1;
      chk($sformatf("%s_halt%0d", tag, i), int'(halt), 0);
      chk($sformatf("%s_smp%0d", tag, i), int'(sample), exp_q[i]);
      chk($sformatf("%s_done_early%0d", tag, i), int'(done), 0);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done"},   int'(done), 1);
    chk({tag, "_result"}, int'(result), exp_res);
    chk({tag, "_halt_done"}, int'(halt), 1);
    chk({tag, "_smp_done"},  int'(sample), 0);
    @(negedge clk);
    chk({tag, "_done_off"}, int'(done), 0);
    chk({tag, "_idle"},     int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] x0, x1, x2, x3;
    int         s0, s1;
    int         res, res_b;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   er;
    int   pulses[$];

    tbl[0] = '{8'd3,   8'd0,  8'd10,  8'd0,   10,   -3,   1, 0};
    tbl[1] = '{8'd20,  8'd0,  8'd10,  8'd0,   10,   -20,  0, 0};
    tbl[2] = '{8'd5,   8'd0,  8'd5,   8'd0,   5,    -5,   1, 0};
    tbl[3] = '{8'd255, 8'd77, 8'd0,   8'd200, 0,    -255, 0, 0};
    tbl[4] = '{8'd0,   8'd9,  8'd255, 8'd0,   255,  0,    1, 1};
    tbl[5] = '{8'd0,   8'd0,  8'd0,   8'd0,   0,    0,    1, 0};

    rst = 1'b1; start = 1'b0; start_n = 1'b0; features = '0; features_n = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_halt",   int'(halt), 1);
    chk("rst_sample", int'(sample), 0);
    chk("rst_clr",    int'(acc_clr), 0);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_done",   int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_n_halt", int'(halt_n), 1);
    rst = 1'b0;

    // Table vectors (scenarios 1-3 and 7 among them).
    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      if (NB != 0) exp_q.push_back(BIASV);
      exp_q.push_back(tbl[v].s0);
      exp_q.push_back(tbl[v].s1);
      run_txn({tbl[v].x3, tbl[v].x2, tbl[v].x1, tbl[v].x0},
              (NB != 0) ? tbl[v].res_b : tbl[v].res, $sformatf("tbl%0d", v));
      if (v == 1) begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          chk($sformatf("hold_res%0d", c), int'(result), (NB != 0) ? tbl[1].res_b : tbl[1].res);
          chk($sformatf("hold_done%0d", c), int'(done), 0);
        end
      end
    end

    // Extremes on the all-negative instance.
    @(negedge clk);
    features_n = 32'hFFFF_FFFF;
    start_n    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_n = 1'b0;
    chk("neg_clr", int'(acc_clr_n), 1);
    er = build_exp(32'hFFFF_FFFF, WSGN_B);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("neg_smp%0d", i), int'(sample_n), exp_q[i]);
      if (i >= NB) chk($sformatf("neg_raw%0d", i), int'({23'd0, sample_n}), 'h101);
    end
    @(negedge clk);
    chk("neg_done",   int'(done_n), 1);
    chk("neg_result", int'(result_n), er);
    chk("neg_acc",    int'(acc_n), -510 + BIASV);

    // Start held high: back-to-back inferences.
    er = build_exp({8'd0, 8'd10, 8'd0, 8'd3}, WSGN_A);
    @(negedge clk);
    features = {8'd0, 8'd10, 8'd0, 8'd3};
    start    = 1'b1;
    for (int c = 0; c < 3 * P; c++) begin
      @(negedge clk);
      if (done) begin
        pulses.push_back(c);
        chk($sformatf("b2b_res%0d", c), int'(result), er);
      end
    end
    start = 1'b0;
    chk("b2b_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk("b2b_first", pulses[0], SIZE + 1 + NB);
      chk("b2b_gap1",  pulses[1] - pulses[0], P);
      chk("b2b_gap2",  pulses[2] - pulses[1], P);
    end
    repeat (P) @(negedge clk);
    chk("b2b_idle", int'(busy), 0);

    // Reset in the second RUN cycle after a result of 1.
    er = build_exp({8'd0, 8'd10, 8'd0, 8'd3}, WSGN_A);
    run_txn({8'd0, 8'd10, 8'd0, 8'd3}, er, "pre_rst");
    @(negedge clk);
    features = {8'd0, 8'd20, 8'd0, 8'd1};
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (NB + 2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_halt",   int'(halt), 1);
    chk("mid_rst_busy",   int'(busy), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_done",   int'(done), 0);
    chk("mid_rst_sample", int'(sample), 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_nodone%0d", c), int'(done), 0);
    end
    er = build_exp({8'd0, 8'd10, 8'd0, 8'd3}, WSGN_A);
    run_txn({8'd0, 8'd10, 8'd0, 8'd3}, er, "post_rst");

    // Randomized inferences against the reference.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] f;
      f  = $urandom;
      er = build_exp(f, WSGN_A);
      run_txn(f, er, $sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
